// File: rtl/bmem_pkg.sv
// Shared types for the burst-memory responder.
// Line request bundle and FSM state encodings.
package bmem_pkg;

  localparam int BMEM_BEATS = 4;
  localparam int BMEM_LINE_BITS = 256;
  localparam int BMEM_CNT_BITS = 8;

  typedef struct packed {
    logic [31:0]               addr;
    logic [BMEM_LINE_BITS-1:0] line;
    logic [BMEM_CNT_BITS-1:0]  cnt;
  } bmem_rd_req_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_B1,
    W_B2,
    W_B3
  } bmem_w_state_e;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } bmem_r_state_e;

endpackage

// File: rtl/bmem_read_fifo.sv
// Circular queue of outstanding line reads.
// Every queued countdown ticks toward zero and holds there.
module bmem_read_fifo
  import bmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  bmem_rd_req_t            push_req,
  input  logic                    pop,
  output bmem_rd_req_t            head,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  bmem_rd_req_t slot [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign head  = slot[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot[i].cnt != '0)
        slot[i].cnt <= slot[i].cnt - BMEM_CNT_BITS'(1);
    end
    if (push) slot[wr_ptr[AW-1:0]] <= push_req;
  end

endmodule

// File: rtl/bmem_responder.sv
// Memory-side end of the bmem line interface: line array,
// four-beat write capture and latency-queued read bursts.
module bmem_responder
  import bmem_pkg::*;
#(
  parameter int READ_LATENCY = 4,
  parameter int QUEUE_DEPTH  = 4,
  parameter int IDX_BITS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [1:0] LAST = 2'(BMEM_BEATS - 1);

  logic [BMEM_LINE_BITS-1:0] mem [2**IDX_BITS];

  bmem_w_state_e w_state;
  bmem_r_state_e r_state;

  logic [IDX_BITS-1:0]       idx;
  logic [IDX_BITS-1:0]       widx;
  logic [191:0]              wbuf;
  logic [BMEM_LINE_BITS-1:0] bline;
  logic [1:0]                beat;
  logic [1:0]                nb;
  logic [CW-1:0]             count;
  logic                      empty;
  bmem_rd_req_t              head;
  bmem_rd_req_t              req;
  bmem_rd_req_t              src;
  logic rd_acc, wr_acc, pop;
  logic due, bypass, free, launch;
  logic unused_addr;

  assign unused_addr = ^bmem_addr[4:0];
  assign idx = bmem_addr[5+IDX_BITS-1:5];

  assign bmem_ready = !rst && w_state == W_IDLE
                      && count < CW'(QUEUE_DEPTH);
  assign rd_acc = bmem_read && bmem_ready;
  assign wr_acc = bmem_write && !bmem_read && bmem_ready;

  // Stored count already reflects the acceptance edge.
  assign req.addr = {bmem_addr[31:5], 5'd0};
  assign req.line = mem[idx];
  assign req.cnt  = BMEM_CNT_BITS'(READ_LATENCY - 1);

  // Beat 0 is registered one cycle ahead of its slot;
  // the entry leaves the queue while beat 0 is on the bus.
  assign due    = !empty && head.cnt <= BMEM_CNT_BITS'(1);
  assign bypass = empty && rd_acc && (READ_LATENCY == 1);
  assign free   = r_state == R_IDLE || beat == LAST;
  assign launch = free && (due || bypass);
  assign src    = due ? head : req;
  assign pop    = r_state == R_BURST && beat == 2'd0;
  assign nb     = beat + 2'd1;

  bmem_read_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_acc),
    .push_req (req),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      beat        <= '0;
      bline       <= '0;
      bmem_rvalid <= 1'b0;
      bmem_rdata  <= '0;
      bmem_raddr  <= '0;
    end else if (launch) begin
      r_state     <= R_BURST;
      beat        <= '0;
      bline       <= src.line;
      bmem_rvalid <= 1'b1;
      bmem_rdata  <= src.line[63:0];
      bmem_raddr  <= src.addr;
    end else if (r_state == R_BURST && beat != LAST) begin
      beat       <= nb;
      bmem_rdata <= bline[{nb, 6'd0} +: 64];
    end else begin
      r_state     <= R_IDLE;
      bmem_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      widx    <= '0;
      wbuf    <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: if (wr_acc) begin
          w_state     <= W_B1;
          widx        <= idx;
          wbuf[63:0]  <= bmem_wdata;
        end
        W_B1: begin
          w_state       <= W_B2;
          wbuf[127:64]  <= bmem_wdata;
        end
        W_B2: begin
          w_state        <= W_B3;
          wbuf[191:128]  <= bmem_wdata;
        end
        W_B3: w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_state == W_B3)
      mem[widx] <= {bmem_wdata, wbuf};
  end

endmodule

// File: tb/tb_bmem_responder.sv
// Randomized bench for bmem_responder against a
// line-level model of the memory and burst schedule.
module tb_bmem_responder;

  localparam int LAT = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 0;
  logic        bmem_write = 0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  bmem_responder #(
    .READ_LATENCY (LAT),
    .QUEUE_DEPTH  (4),
    .IDX_BITS     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [63:0] d;
    logic [31:0] a;
  } beat_t;

  beat_t        exq[$];
  logic [255:0] mm [256];
  int cyc = 0;
  int last_end = -100;
  int last_acc = 0;
  int total = 0;
  int bad = 0;
  bit mon_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (exq.size() > 0 && exq[0].c == cyc) begin
        chk("rvalid", 64'(bmem_rvalid), 64'd1);
        chk("rdata", bmem_rdata, exq[0].d);
        chk("raddr", 64'(bmem_raddr), 64'(exq[0].a));
        void'(exq.pop_front());
      end else begin
        chk("rquiet", 64'(bmem_rvalid), 64'd0);
      end
    end
  end

  function automatic logic [255:0] rnd_line();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic wr_line(input logic [31:0] a,
                         input logic [255:0] d);
    int w = 0;
    while (!bmem_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!bmem_ready) begin
      chk("wr_wait", 64'(bmem_ready), 64'd1);
      return;
    end
    bmem_write = 1;
    bmem_read  = 0;
    bmem_addr  = a;
    bmem_wdata = d[63:0];
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      chk("wr_busy", 64'(bmem_ready), 64'd0);
      bmem_wdata = d[64*b +: 64];
    end
    @(negedge clk);
    bmem_write = 0;
    mm[a[12:5]] = d;
    chk("wr_done", 64'(bmem_ready), 64'd1);
  endtask

  task automatic rd_line(input logic [31:0] a, input bit wr);
    int w = 0;
    int s;
    beat_t e;
    while (!bmem_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!bmem_ready) begin
      chk("rd_wait", 64'(bmem_ready), 64'd1);
      return;
    end
    bmem_read  = 1;
    bmem_write = wr;
    bmem_addr  = a;
    bmem_wdata = {$urandom, $urandom};
    last_acc = cyc;
    s = (cyc + LAT > last_end + 1) ? cyc + LAT : last_end + 1;
    for (int b = 0; b < 4; b++) begin
      e.c = s + b;
      e.d = mm[a[12:5]][64*b +: 64];
      e.a = {a[31:5], 5'd0};
      exq.push_back(e);
    end
    last_end = s + 3;
    @(negedge clk);
    bmem_read  = 0;
    bmem_write = 0;
  endtask

  task automatic drain();
    int w = 0;
    while (exq.size() != 0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    chk("drain", 64'(exq.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    logic [31:0]  a;
    int           ix;

    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(bmem_ready), 64'd0);
    chk("rst_rvalid", 64'(bmem_rvalid), 64'd0);
    chk("rst_rdata", bmem_rdata, 64'd0);
    chk("rst_raddr", 64'(bmem_raddr), 64'd0);
    rst = 0;
    mon_on = 1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      wr_line(32'(i) << 5, rnd_line());

    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wr_line(32'h1ece_b000, d);
    rd_line(32'h1ece_b000, 0);
    drain();

    for (int i = 0; i < 4; i++)
      rd_line(32'h0100_0000 * (i + 1) | (32'(i) << 5), 0);
    chk("full_rdy", 64'(bmem_ready), 64'd0);
    drain();

    wr_line(32'h0000_0020, rnd_line());
    rd_line(32'h2000_0020, 0);
    drain();

    rd_line(32'h0000_0040, 1);
    drain();
    rd_line(32'h0000_0040, 0);
    drain();

    rd_line(32'h0000_0060, 0);
    while (cyc < last_acc + LAT + 1) @(negedge clk);
    #1;
    rst = 1;
    exq.delete();
    last_end = -100;
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(bmem_rvalid), 64'd0);
    chk("rst_mid_rdy", 64'(bmem_ready), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("rst_after_rdy", 64'(bmem_ready), 64'd1);

    chk("pw_rdy", 64'(bmem_ready), 64'd1);
    d = rnd_line();
    bmem_write = 1;
    bmem_addr  = 32'h0000_00a0;
    bmem_wdata = d[63:0];
    @(negedge clk);
    bmem_wdata = d[127:64];
    @(negedge clk);
    rst = 1;
    bmem_wdata = d[191:128];
    @(negedge clk);
    rst = 0;
    bmem_write = 0;
    rd_line(32'h0000_00a0, 0);
    drain();

    for (int i = 0; i < 80; i++) begin
      ix = $urandom_range(0, 7);
      a = ($urandom & 32'hffff_e01f) | (32'(ix) << 5);
      if ($urandom_range(0, 9) < 3) wr_line(a, rnd_line());
      else rd_line(a, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
